// File: rtl/posit_round_seq_if.sv
// Handshake and data bundle between the posit encode path and posit_round_seq.
interface posit_round_seq_if #(
    parameter int MANT_W = 64,
    parameter int OUT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] in_mant;
    logic [7:0]        in_k;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_mant;
    logic [5:0]        out_bt;
    logic [5:0]        out_shift;
    logic              out_carry;
    logic              out_inexact;
    logic              out_zero;

    // Upstream producer / downstream consumer side (drives requests, accepts results)
    modport master (
        output in_valid, in_mant, in_k, out_ready,
        input  in_ready, out_valid, out_mant, out_bt, out_shift,
               out_carry, out_inexact, out_zero
    );

    // Rounding block side
    modport slave (
        input  in_valid, in_mant, in_k, out_ready,
        output in_ready, out_valid, out_mant, out_bt, out_shift,
               out_carry, out_inexact, out_zero
    );
endinterface

// File: rtl/posit_round_seq.sv
// Sequential normalize-and-round controller: left-normalizes a 64-bit mantissa
// one bit per cycle, then rounds to a (26 - |k|)-bit field with RNE.
module posit_round_seq #(
    parameter int MANT_W = 64,
    parameter int OUT_W  = 32
) (
    input logic             clk,
    input logic             rst_n,
    posit_round_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t            state_q, state_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [7:0]        k_q, k_d;
    logic [5:0]        shift_q, shift_d;
    logic [OUT_W-1:0]  omant_q, omant_d;
    logic [5:0]        obt_q, obt_d;
    logic [5:0]        oshift_q, oshift_d;
    logic              ocarry_q, ocarry_d;
    logic              oinexact_q, oinexact_d;
    logic              ozero_q, ozero_d;

    logic [7:0]        abs_k;
    logic signed [8:0] bt_s;
    logic [5:0]        bt;
    logic [OUT_W-1:0]  kept;
    logic [OUT_W-1:0]  field;
    logic [MANT_W-1:0] below;
    logic              guard, sticky, round_up;
    logic [OUT_W:0]    rounded;
    logic [OUT_W-1:0]  r_mant;
    logic [5:0]        r_bt;
    logic              r_carry, r_inexact;

    // Rounding datapath on the normalized mantissa register
    always_comb begin
        abs_k = k_q;
        if (k_q[7]) abs_k = (k_q == 8'h80) ? 8'd127 : (~k_q + 8'd1);
        bt_s  = 9'sd26 - $signed({1'b0, abs_k});
        bt    = bt_s[5:0];
        // kept = top bt bits right-justified; below = discarded bits, guard at MSB
        kept     = 32'(mant_q >> (7'd64 - {1'b0, bt}));
        below    = mant_q << bt;
        guard    = below[63];
        sticky   = |below[62:0];
        round_up = guard && (sticky || kept[0]);
        field    = kept << (6'd32 - bt);
        rounded  = {1'b0, field} + (round_up ? (33'd1 << (6'd32 - bt)) : 33'd0);

        r_mant    = '0;
        r_bt      = '0;
        r_carry   = 1'b0;
        r_inexact = |mant_q;
        if (bt_s > 9'sd0) begin
            r_bt      = bt;
            r_carry   = rounded[32];
            r_mant    = rounded[32] ? '0 : rounded[31:0];
            r_inexact = guard || sticky;
        end
    end

    // Next-state, working registers and result capture
    always_comb begin
        state_d    = state_q;
        mant_d     = mant_q;
        k_d        = k_q;
        shift_d    = shift_q;
        omant_d    = omant_q;
        obt_d      = obt_q;
        oshift_d   = oshift_q;
        ocarry_d   = ocarry_q;
        oinexact_d = oinexact_q;
        ozero_d    = ozero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mant_d  = bus.in_mant;
                    k_d     = bus.in_k;
                    shift_d = '0;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mant_q == '0) begin
                    omant_d    = '0;
                    obt_d      = '0;
                    oshift_d   = '0;
                    ocarry_d   = 1'b0;
                    oinexact_d = 1'b0;
                    ozero_d    = 1'b1;
                    state_d    = DONE;
                end else if (mant_q[63]) begin
                    state_d = ROUND;
                end else begin
                    mant_d  = mant_q << 1;
                    shift_d = shift_q + 6'd1;
                end
            end
            ROUND: begin
                omant_d    = r_mant;
                obt_d      = r_bt;
                oshift_d   = shift_q;
                ocarry_d   = r_carry;
                oinexact_d = r_inexact;
                ozero_d    = 1'b0;
                state_d    = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and data registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mant_q     <= '0;
            k_q        <= '0;
            shift_q    <= '0;
            omant_q    <= '0;
            obt_q      <= '0;
            oshift_q   <= '0;
            ocarry_q   <= 1'b0;
            oinexact_q <= 1'b0;
            ozero_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mant_q     <= mant_d;
            k_q        <= k_d;
            shift_q    <= shift_d;
            omant_q    <= omant_d;
            obt_q      <= obt_d;
            oshift_q   <= oshift_d;
            ocarry_q   <= ocarry_d;
            oinexact_q <= oinexact_d;
            ozero_q    <= ozero_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.out_mant    = omant_q;
    assign bus.out_bt      = obt_q;
    assign bus.out_shift   = oshift_q;
    assign bus.out_carry   = ocarry_q;
    assign bus.out_inexact = oinexact_q;
    assign bus.out_zero    = ozero_q;
endmodule

// File: tb/tb_posit_round_seq.sv
// Scoreboard bench for posit_round_seq: a driver pushes reference results,
// an independent monitor pops and compares on each output handshake.
module tb_posit_round_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hold_low = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic prev_v = 1'b0;

    typedef struct {
        logic [31:0] mant;
        logic [5:0]  bt;
        logic [5:0]  shift;
        logic        carry;
        logic        inexact;
        logic        zero;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    posit_round_seq_if #(.MANT_W(64), .OUT_W(32)) bus ();

    posit_round_seq #(.MANT_W(64), .OUT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [46:0] outs();
        return {bus.out_mant, bus.out_bt, bus.out_shift, bus.out_carry, bus.out_inexact, bus.out_zero};
    endfunction

    // Reference: value-level RNE using the remainder against one half-ulp
    function automatic exp_t model(input logic [63:0] m, input logic [7:0] k);
        exp_t e;
        int lz, ak, bt;
        logic [63:0] n, f, r, half;
        logic up;
        e.mant = '0; e.bt = '0; e.shift = '0; e.carry = 0; e.inexact = 0; e.zero = 0; e.acc = 0;
        if (m == 64'd0) begin
            e.zero = 1;
            e.lat  = 1;
            return e;
        end
        lz = 0;
        n = m;
        while (!n[63]) begin
            n = n << 1;
            lz++;
        end
        e.shift = 6'(lz);
        e.lat = lz + 2;
        ak = int'($signed(k));
        if (ak < 0) ak = -ak;
        if (ak > 127) ak = 127;
        bt = 26 - ak;
        if (bt <= 0) begin
            e.inexact = 1;
            return e;
        end
        e.bt = 6'(bt);
        f    = n >> (64 - bt);
        r    = n & ((64'd1 << (64 - bt)) - 64'd1);
        half = 64'd1 << (63 - bt);
        up   = (r > half) || (r == half && f[0]);
        f    = f + {63'd0, up};
        e.inexact = (r != 64'd0);
        if (f == (64'd1 << bt)) e.carry = 1;
        else e.mant = 32'(f << (32 - bt));
        return e;
    endfunction

    task automatic send(input logic [63:0] m, input logic [7:0] k);
        exp_t e;
        int t = 0;
        while (!bus.in_ready && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!bus.in_ready) begin
            chk("send_timeout", 64'(bus.in_ready), 64'd1);
            return;
        end
        e = model(m, k);
        bus.in_valid = 1'b1;
        bus.in_mant  = m;
        bus.in_k     = k;
        @(posedge clk);
        #1;
        e.acc = cyc;
        sb.push_back(e);
        bus.in_valid = 1'b0;
        bus.in_mant  = {$urandom, $urandom};
        bus.in_k     = 8'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    // Downstream ready: random, or forced low for backpressure
    always @(posedge clk) begin
        #1;
        bus.out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: latency at out_valid rise, result at handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid && !prev_v) begin
                if (sb.size() == 0) chk("unexpected_valid", 64'(bus.out_valid), 64'd0);
                else chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'(outs()), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result", 64'(outs()),
                        64'({e.mant, e.bt, e.shift, e.carry, e.inexact, e.zero}));
                end
            end
            prev_v = bus.out_valid;
        end
    end

    initial begin
        logic [46:0] snap;
        logic [63:0] m;
        logic [7:0]  k;
        int t;
        bus.in_valid = 1'b0;
        bus.in_mant  = '0;
        bus.in_k     = '0;
        bus.out_ready = 1'b0;

        #12;
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_outputs", 64'(outs()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        send(64'h8000_0000_0000_0000, 8'd0);
        send(64'h8000_0060_0000_0000, 8'd0);
        send(64'h8000_0020_0000_0000, 8'd0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 8'd0);
        send(64'h0000_0000_0000_0001, 8'd3);
        send(64'hC000_0000_0000_0000, 8'hE6);
        send(64'h0000_0000_0000_0000, 8'd5);
        send(64'h1234_5678_9ABC_DEF0, 8'h80);
        send(64'h8000_0000_0000_0001, 8'd25);
        send(64'hFFFF_FFFF_FFFF_FFFF, 8'hE7);
        drain();

        // Backpressure: results held, new requests ignored
        hold_low = 1'b1;
        @(posedge clk);
        #2;
        send(64'h0000_0000_8000_0060, 8'hFE);
        t = 0;
        while (!bus.out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("stall_valid_seen", 64'(bus.out_valid), 64'd1);
        snap = outs();
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_mant  = {$urandom, $urandom};
            bus.in_k     = 8'($urandom);
            @(negedge clk);
            chk("stall_hold", 64'(outs()), 64'(snap));
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        hold_low = 1'b0;
        drain();

        // Reset mid-normalization discards the result
        send(64'h0000_0000_0000_0001, 8'd3);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midreset_outputs", 64'(outs()), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(64'h0000_0F00_0000_0000, 8'd1);
        drain();

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            m = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0: m = '0;
                1: m = 64'hFFFF_FFFF_FFFF_FFFF << $urandom_range(0, 40);
                2: m = m | 64'h8000_0000_0000_0000;
                default: m = m >> $urandom_range(0, 63);
            endcase
            if ($urandom_range(0, 4) == 0) k = 8'($urandom);
            else k = 8'($urandom_range(0, 60)) - 8'd30;
            send(m, k);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
